rv32i_idtop: RTL and testbench
==============================

RV32I_IDTOP -- requirements
Module: rv32i_idTop

Interface
REQ-001 Parameter: NOP_IW, 32'h0000_0013, bubble instruction word (addi x0,x0,0) sent to EX.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 iw_in  input  32  instruction word from IF, valid every cycle.
REQ-005 pc_in  input  32  PC of iw_in, from IF.
REQ-006 jump_en_in  input  1  squash flag from IF: iw_in is wrong-path.
REQ-007 rs1_reg, rs2_reg  output  5 each  register-file read addresses, combinational from iw_in[19:15] and iw_in[24:20].
REQ-008 rs1_data, rs2_data  input  32 each  register-file read data, same cycle.
REQ-009 ex_wb_reg, mem_wb_reg, wb_wb_reg  input  5 each  destinations of instructions in EX/MEM/WB.
REQ-010 ex_wb_en, mem_wb_en, wb_wb_en  input  1 each  write-enables matching REQ-009.
REQ-011 jump_en_out  output  1  redirect IF this cycle (combinational).
REQ-012 jump_addr  output  32  redirect target (combinational).
REQ-013 pc_halt_out  output  1  stall IF this cycle (combinational).
REQ-014 iw_out, pc_out, rs1_data_out, rs2_data_out, imm_out  output  32 each  registered to EX.
REQ-015 wb_reg_out  output  5, wb_en_out  output  1  registered destination and write-enable to EX.

Function
REQ-016 "valid" SHALL be !jump_en_in; an invalid instruction is a bubble: no jump, no halt, bubble to EX.
REQ-017 Immediate SHALL be sign-extended per format: I (LOAD, OP-IMM, JALR), S (STORE), B (BRANCH), U (LUI, AUIPC, low 12 bits zero), J (JAL); other opcodes imm=0.
REQ-018 rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP; rs2 used by BRANCH, STORE, OP.
REQ-019 Hazard SHALL be 1 when valid and a used rsN != 0 equals any stage wb_reg whose wb_en=1.
REQ-020 pc_halt_out SHALL equal hazard.
REQ-021 When hazard=1: no jump; registered outputs take bubble (iw_out=NOP_IW, wb_en_out=0, wb_reg_out=0, imm_out=0, data=0, pc_out=pc_in); IF keeps iw_in/pc_in stable (upstream contract).
REQ-022 When valid and !hazard: JAL -> jump_en_out=1, jump_addr=pc_in+immJ.
REQ-023 JALR -> jump_en_out=1, jump_addr=(rs1_data+immI)&32'hFFFF_FFFE.
REQ-024 BRANCH funct3 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU; taken -> jump_en_out=1, jump_addr=pc_in+immB; funct3 010/011 never taken.
REQ-025 Otherwise jump_en_out=0, jump_addr=32'h0.
REQ-026 All address arithmetic SHALL be 32-bit modulo 2^32 (wrap, no overflow flag).
REQ-027 wb_en_out SHALL be 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP with rd!=0; else 0; wb_reg_out=rd when wb_en_out=1, else 0.
REQ-028 Unknown opcode SHALL be treated as a bubble (no jump, wb_en_out=0, iw_out=NOP_IW).
REQ-029 Valid, non-hazard instruction: registered outputs SHALL capture iw_in, pc_in, rs1_data, rs2_data, imm, one-cycle latency.
REQ-030 jump_en_in=1 with hazard conditions present: squash wins, pc_halt_out=0.
REQ-031 Taken jump SHALL be asserted one cycle only; the instruction following it arrives with jump_en_in=1 and is squashed.

Reset
REQ-032 reset=1 at posedge: iw_out=NOP_IW, pc_out=0, rs1_data_out=0, rs2_data_out=0, imm_out=0, wb_reg_out=0, wb_en_out=0.
REQ-033 While reset=1, jump_en_out=0 and pc_halt_out=0 regardless of inputs; reset mid-stall releases halt the same cycle.

Verification
REQ-034 Reset: reset=1 one cycle -> iw_out=32'h0000_0013, all other registered outputs 0, jump_en_out=0.
REQ-035 RAW hazard: iw_in=add x3,x1,x2, mem_wb_reg=1, mem_wb_en=1 -> pc_halt_out=1, next iw_out=NOP_IW; mem_wb_en=0 -> pc_halt_out=0, next iw_out=add, wb_reg_out=3.
REQ-036 x0 ignore: iw_in=add x3,x0,x0, ex_wb_reg=0, ex_wb_en=1 -> pc_halt_out=0.
REQ-037 Branch: pc_in=32'h100, BLT, immB=-8, rs1_data=32'hFFFF_FFFF, rs2_data=1 -> jump_en_out=1, jump_addr=32'hF8; same operands BLTU -> jump_en_out=0.
REQ-038 JALR/wrap: rs1_data=32'hFFFF_FFFF, immI=4 -> jump_addr=32'h2; JAL pc_in=32'hFFFF_FFFC, immJ=8 -> jump_addr=32'h4, wb_en_out=1 if rd!=0.
REQ-039 Squash: jump_en_in=1 with JAL and active hazard -> jump_en_out=0, pc_halt_out=0, next iw_out=NOP_IW, wb_en_out=0.

Source files
------------

// File: rtl/rv32i_idtop.sv
// RV32I decode stage: immediate generation, RAW hazard stall, branch/jump resolution,
// and the ID/EX pipeline register.
module rv32i_idtop #(
   parameter logic [31:0] NOP_IW = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] iw_in,
   input  logic [31:0] pc_in,
   input  logic        jump_en_in,
   output logic [4:0]  rs1_reg,
   output logic [4:0]  rs2_reg,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic [4:0]  ex_wb_reg,
   input  logic [4:0]  mem_wb_reg,
   input  logic [4:0]  wb_wb_reg,
   input  logic        ex_wb_en,
   input  logic        mem_wb_en,
   input  logic        wb_wb_en,
   output logic        jump_en_out,
   output logic [31:0] jump_addr,
   output logic        pc_halt_out,
   output logic [31:0] iw_out,
   output logic [31:0] pc_out,
   output logic [31:0] rs1_data_out,
   output logic [31:0] rs2_data_out,
   output logic [31:0] imm_out,
   output logic [4:0]  wb_reg_out,
   output logic        wb_en_out
);

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpReg    = 7'b0110011;

   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode  = iw_in[6:0];
   assign rd      = iw_in[11:7];
   assign funct3  = iw_in[14:12];
   assign rs1_reg = iw_in[19:15];
   assign rs2_reg = iw_in[24:20];

   assign imm_i = {{20{iw_in[31]}}, iw_in[31:20]};
   assign imm_s = {{20{iw_in[31]}}, iw_in[31:25], iw_in[11:7]};
   assign imm_b = {{19{iw_in[31]}}, iw_in[31], iw_in[7], iw_in[30:25], iw_in[11:8], 1'b0};
   assign imm_u = {iw_in[31:12], 12'h000};
   assign imm_j = {{11{iw_in[31]}}, iw_in[31], iw_in[19:12], iw_in[20], iw_in[30:21], 1'b0};

   logic        known, use_rs1, use_rs2, writes_rd, is_jal, is_jalr, is_branch;
   logic [31:0] imm;

   always_comb begin
      known     = 1'b0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      writes_rd = 1'b0;
      is_jal    = 1'b0;
      is_jalr   = 1'b0;
      is_branch = 1'b0;
      imm       = 32'h0;
      case (opcode)
         OpLui, OpAuipc: begin
            known     = 1'b1;
            writes_rd = 1'b1;
            imm       = imm_u;
         end
         OpJal: begin
            known     = 1'b1;
            writes_rd = 1'b1;
            is_jal    = 1'b1;
            imm       = imm_j;
         end
         OpJalr: begin
            known     = 1'b1;
            writes_rd = 1'b1;
            is_jalr   = 1'b1;
            use_rs1   = 1'b1;
            imm       = imm_i;
         end
         OpBranch: begin
            known     = 1'b1;
            is_branch = 1'b1;
            use_rs1   = 1'b1;
            use_rs2   = 1'b1;
            imm       = imm_b;
         end
         OpLoad, OpImm: begin
            known     = 1'b1;
            writes_rd = 1'b1;
            use_rs1   = 1'b1;
            imm       = imm_i;
         end
         OpStore: begin
            known   = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            imm     = imm_s;
         end
         OpReg: begin
            known     = 1'b1;
            writes_rd = 1'b1;
            use_rs1   = 1'b1;
            use_rs2   = 1'b1;
         end
         default: ;
      endcase
   end

   function automatic logic pending_write(input logic [4:0] r);
      return (ex_wb_en && ex_wb_reg == r) || (mem_wb_en && mem_wb_reg == r) ||
             (wb_wb_en && wb_wb_reg == r);
   endfunction

   logic valid, hazard, br_taken;

   assign valid  = !jump_en_in;
   // x0 is never a true dependency, whatever the later stages claim to write
   assign hazard = valid &&
                   ((use_rs1 && rs1_reg != 5'd0 && pending_write(rs1_reg)) ||
                    (use_rs2 && rs2_reg != 5'd0 && pending_write(rs2_reg)));

   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         3'b000:  br_taken = rs1_data == rs2_data;
         3'b001:  br_taken = rs1_data != rs2_data;
         3'b100:  br_taken = $signed(rs1_data) <  $signed(rs2_data);
         3'b101:  br_taken = $signed(rs1_data) >= $signed(rs2_data);
         3'b110:  br_taken = rs1_data <  rs2_data;
         3'b111:  br_taken = rs1_data >= rs2_data;
         default: br_taken = 1'b0;
      endcase
   end

   logic go;

   assign go          = valid && !hazard && !reset;
   assign pc_halt_out = hazard && !reset;

   always_comb begin
      jump_en_out = 1'b0;
      jump_addr   = 32'h0;
      if (go && is_jal) begin
         jump_en_out = 1'b1;
         jump_addr   = pc_in + imm_j;
      end else if (go && is_jalr) begin
         jump_en_out = 1'b1;
         jump_addr   = (rs1_data + imm_i) & 32'hFFFF_FFFE;
      end else if (go && is_branch && br_taken) begin
         jump_en_out = 1'b1;
         jump_addr   = pc_in + imm_b;
      end
   end

   logic        pass;
   logic [31:0] iw_d, rs1_data_d, rs2_data_d, imm_d;
   logic [4:0]  wb_reg_d;
   logic        wb_en_d;
   logic [31:0] iw_q, pc_q, rs1_data_q, rs2_data_q, imm_q;
   logic [4:0]  wb_reg_q;
   logic        wb_en_q;

   // Squashed, stalled and undecodable words all leave as the same bubble
   assign pass = valid && known && !hazard;

   always_comb begin
      iw_d       = NOP_IW;
      rs1_data_d = 32'h0;
      rs2_data_d = 32'h0;
      imm_d      = 32'h0;
      wb_reg_d   = 5'd0;
      wb_en_d    = 1'b0;
      if (pass) begin
         iw_d       = iw_in;
         rs1_data_d = rs1_data;
         rs2_data_d = rs2_data;
         imm_d      = imm;
         if (writes_rd && rd != 5'd0) begin
            wb_reg_d = rd;
            wb_en_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         iw_q       <= NOP_IW;
         pc_q       <= 32'h0;
         rs1_data_q <= 32'h0;
         rs2_data_q <= 32'h0;
         imm_q      <= 32'h0;
         wb_reg_q   <= 5'd0;
         wb_en_q    <= 1'b0;
      end else begin
         iw_q       <= iw_d;
         pc_q       <= pc_in;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         wb_reg_q   <= wb_reg_d;
         wb_en_q    <= wb_en_d;
      end
   end

   assign iw_out       = iw_q;
   assign pc_out       = pc_q;
   assign rs1_data_out = rs1_data_q;
   assign rs2_data_out = rs2_data_q;
   assign imm_out      = imm_q;
   assign wb_reg_out   = wb_reg_q;
   assign wb_en_out    = wb_en_q;

endmodule

// File: tb/tb_rv32i_idtop.sv
// Directed-vector bench for rv32i_idtop; expectations are queued by the driver and
// checked by an independent monitor (comb outputs mid-cycle, registered outputs after the edge).
module tb_rv32i_idtop;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] iw_in, pc_in, rs1_data, rs2_data;
   logic        jump_en_in;
   logic [4:0]  rs1_reg, rs2_reg, ex_wb_reg, mem_wb_reg, wb_wb_reg;
   logic        ex_wb_en, mem_wb_en, wb_wb_en;
   logic        jump_en_out, pc_halt_out, wb_en_out;
   logic [31:0] jump_addr, iw_out, pc_out, rs1_data_out, rs2_data_out, imm_out;
   logic [4:0]  wb_reg_out;

   always #5 clk = ~clk;

   rv32i_idtop #(.NOP_IW(32'h0000_0013)) dut (
      .clk          (clk),
      .reset        (reset),
      .iw_in        (iw_in),
      .pc_in        (pc_in),
      .jump_en_in   (jump_en_in),
      .rs1_reg      (rs1_reg),
      .rs2_reg      (rs2_reg),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .ex_wb_reg    (ex_wb_reg),
      .mem_wb_reg   (mem_wb_reg),
      .wb_wb_reg    (wb_wb_reg),
      .ex_wb_en     (ex_wb_en),
      .mem_wb_en    (mem_wb_en),
      .wb_wb_en     (wb_wb_en),
      .jump_en_out  (jump_en_out),
      .jump_addr    (jump_addr),
      .pc_halt_out  (pc_halt_out),
      .iw_out       (iw_out),
      .pc_out       (pc_out),
      .rs1_data_out (rs1_data_out),
      .rs2_data_out (rs2_data_out),
      .imm_out      (imm_out),
      .wb_reg_out   (wb_reg_out),
      .wb_en_out    (wb_en_out)
   );

   typedef struct {
      string       nm;
      logic [4:0]  rs1, rs2;
      logic        jmp, halt;
      logic [31:0] jaddr;
      logic [31:0] iw, pc, r1, r2, imm;
      logic [4:0]  wbr;
      logic        wbe;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic busy  = 1'b0;

   function automatic void chk(string nm, string fld, logic [31:0] act, logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s.%s: got %h, required %h", nm, fld, act, req);
      end
   endfunction

   // Monitor: comb outputs on the falling edge, registered outputs just after the rising edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            busy = 1'b1;
            e = q.pop_front();
            chk(e.nm, "rs1_reg", {27'h0, rs1_reg}, {27'h0, e.rs1});
            chk(e.nm, "rs2_reg", {27'h0, rs2_reg}, {27'h0, e.rs2});
            chk(e.nm, "jump_en", {31'h0, jump_en_out}, {31'h0, e.jmp});
            chk(e.nm, "jump_addr", jump_addr, e.jaddr);
            chk(e.nm, "halt", {31'h0, pc_halt_out}, {31'h0, e.halt});
            @(posedge clk);
            #1;
            chk(e.nm, "iw_out", iw_out, e.iw);
            chk(e.nm, "pc_out", pc_out, e.pc);
            chk(e.nm, "rs1_data_out", rs1_data_out, e.r1);
            chk(e.nm, "rs2_data_out", rs2_data_out, e.r2);
            chk(e.nm, "imm_out", imm_out, e.imm);
            chk(e.nm, "wb_reg_out", {27'h0, wb_reg_out}, {27'h0, e.wbr});
            chk(e.nm, "wb_en_out", {31'h0, wb_en_out}, {31'h0, e.wbe});
            busy = 1'b0;
         end
      end
   end

   task automatic vec(
      input string nm, input logic rst, input logic jin, input logic [31:0] iw,
      input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
      input logic [4:0] exr, input logic exe, input logic [4:0] memr, input logic meme,
      input logic [4:0] wbr, input logic wbe,
      input logic [4:0] ers1, input logic [4:0] ers2, input logic ejmp,
      input logic [31:0] eaddr, input logic ehalt,
      input logic [31:0] eiw, input logic [31:0] epc, input logic [31:0] er1,
      input logic [31:0] er2, input logic [31:0] eimm, input logic [4:0] ewbr,
      input logic ewbe);
      exp_t e;
      @(posedge clk);
      #2;
      reset      = rst;
      jump_en_in = jin;
      iw_in      = iw;
      pc_in      = pc;
      rs1_data   = d1;
      rs2_data   = d2;
      ex_wb_reg  = exr;
      ex_wb_en   = exe;
      mem_wb_reg = memr;
      mem_wb_en  = meme;
      wb_wb_reg  = wbr;
      wb_wb_en   = wbe;
      e = '{nm: nm, rs1: ers1, rs2: ers2, jmp: ejmp, halt: ehalt, jaddr: eaddr,
            iw: eiw, pc: epc, r1: er1, r2: er2, imm: eimm, wbr: ewbr, wbe: ewbe};
      q.push_back(e);
   endtask

   localparam logic [31:0] Nop  = 32'h0000_0013;
   localparam logic [31:0] Add  = 32'h0020_81B3;  // add  x3,x1,x2
   localparam logic [31:0] Add0 = 32'h0000_01B3;  // add  x3,x0,x0
   localparam logic [31:0] Blt  = 32'hFE20_CCE3;  // blt  x1,x2,-8
   localparam logic [31:0] Bltu = 32'hFE20_ECE3;  // bltu x1,x2,-8
   localparam logic [31:0] Jalr = 32'h0040_82E7;  // jalr x5,4(x1)
   localparam logic [31:0] Jal  = 32'h0080_00EF;  // jal  x1,+8
   localparam logic [31:0] Lui  = 32'h1234_53B7;  // lui  x7,0x12345
   localparam logic [31:0] Sw   = 32'hFE20_AE23;  // sw   x2,-4(x1)
   localparam logic [31:0] Bad  = 32'hFFFF_FFFF;
   localparam logic [31:0] Addi = 32'h0050_0013;  // addi x0,x0,5

   initial begin
      reset = 1'b1; jump_en_in = 1'b0; iw_in = Nop; pc_in = '0; rs1_data = '0; rs2_data = '0;
      ex_wb_reg = '0; mem_wb_reg = '0; wb_wb_reg = '0;
      ex_wb_en = 1'b0; mem_wb_en = 1'b0; wb_wb_en = 1'b0;

      // name rst jin iw pc d1 d2 | exr exe memr meme wbr wbe | rs1 rs2 jmp addr halt |
      // iw pc r1 r2 imm wbr wbe
      vec("reset_stall", 1, 0, Add, 32'h40, 32'h11, 32'h22, 0, 0, 1, 1, 0, 0,
          1, 2, 0, 0, 0, Nop, 0, 0, 0, 0, 0, 0);
      vec("raw_stall", 0, 0, Add, 32'h40, 32'h11, 32'h22, 0, 0, 1, 1, 0, 0,
          1, 2, 0, 0, 1, Nop, 32'h40, 0, 0, 0, 0, 0);
      vec("raw_release", 0, 0, Add, 32'h40, 32'h11, 32'h22, 0, 0, 1, 0, 0, 0,
          1, 2, 0, 0, 0, Add, 32'h40, 32'h11, 32'h22, 0, 3, 1);
      vec("x0_ignore", 0, 0, Add0, 32'h44, 0, 0, 0, 1, 0, 0, 0, 0,
          0, 0, 0, 0, 0, Add0, 32'h44, 0, 0, 0, 3, 1);
      vec("rs2_wb_haz", 0, 0, Add, 32'h48, 32'h5, 32'h6, 0, 0, 0, 0, 2, 1,
          1, 2, 0, 0, 1, Nop, 32'h48, 0, 0, 0, 0, 0);
      vec("blt_taken", 0, 0, Blt, 32'h100, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0,
          1, 2, 1, 32'hF8, 0, Blt, 32'h100, 32'hFFFF_FFFF, 1, 32'hFFFF_FFF8, 0, 0);
      vec("bltu_not", 0, 0, Bltu, 32'h100, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0,
          1, 2, 0, 0, 0, Bltu, 32'h100, 32'hFFFF_FFFF, 1, 32'hFFFF_FFF8, 0, 0);
      vec("jalr_wrap", 0, 0, Jalr, 32'h200, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0,
          1, 4, 1, 32'h2, 0, Jalr, 32'h200, 32'hFFFF_FFFF, 0, 32'h4, 5, 1);
      vec("jal_wrap", 0, 0, Jal, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0,
          0, 8, 1, 32'h4, 0, Jal, 32'hFFFF_FFFC, 0, 0, 32'h8, 1, 1);
      vec("squash_jal", 0, 1, Jal, 32'h300, 0, 0, 1, 1, 2, 1, 3, 1,
          0, 8, 0, 0, 0, Nop, 32'h300, 0, 0, 0, 0, 0);
      vec("squash_haz", 0, 1, Add, 32'h304, 32'h11, 32'h22, 0, 0, 1, 1, 0, 0,
          1, 2, 0, 0, 0, Nop, 32'h304, 0, 0, 0, 0, 0);
      vec("lui", 0, 0, Lui, 32'h400, 32'h5, 32'h6, 8, 1, 0, 0, 0, 0,
          8, 3, 0, 0, 0, Lui, 32'h400, 32'h5, 32'h6, 32'h1234_5000, 7, 1);
      vec("store", 0, 0, Sw, 32'h404, 32'h1000, 32'hAB, 0, 0, 0, 0, 0, 0,
          1, 2, 0, 0, 0, Sw, 32'h404, 32'h1000, 32'hAB, 32'hFFFF_FFFC, 0, 0);
      vec("unknown_op", 0, 0, Bad, 32'h408, 32'h7, 32'h8, 31, 1, 0, 0, 0, 0,
          31, 31, 0, 0, 0, Nop, 32'h408, 0, 0, 0, 0, 0);
      vec("addi_x0", 0, 0, Addi, 32'h40C, 32'h9, 32'hA, 0, 0, 0, 0, 0, 0,
          0, 5, 0, 0, 0, Addi, 32'h40C, 32'h9, 32'hA, 32'h5, 0, 0);
      vec("jalr_haz", 0, 0, Jalr, 32'h500, 32'h1000, 0, 1, 1, 0, 0, 0, 0,
          1, 4, 0, 0, 1, Nop, 32'h500, 0, 0, 0, 0, 0);
      vec("reset_jal", 1, 0, Jal, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0,
          0, 8, 0, 0, 0, Nop, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 20 && (q.size() != 0 || busy); i++) @(posedge clk);
      #3;
      if (q.size() != 0 || busy) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d entries left, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
